// File: rtl/fifo_pkt_ctrl.sv
// Packet sequencer for the 128x8 fifo: length write, byte load with level-held write strobes,
// then drain to a valid/ready sink. Define FIFO_PKT_TIMEOUT_EN to abort a stalled load.
module fifo_pkt_ctrl #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned STROBE_HI   = 2,
  parameter int unsigned STROBE_LO   = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_cfg_len,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic [7:0] o_m_data,
  output logic       o_m_valid,
  input  logic       i_m_ready,
  output logic       o_fifo_wr_en,
  output logic       o_fifo_rd_en,
  output logic       o_fifo_length_wr_en,
  output logic       o_fifo_length_rd_en,
  output logic [7:0] o_fifo_data_in,
  output logic [7:0] o_fifo_length_in,
  input  logic [7:0] i_fifo_data_out,
  input  logic       i_fifo_full,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [3:0] {
    StIdle, StCfg, StLdWait, StWrHi, StWrLo, StRdHi, StRdHold, StRdLo, StFin, StAbort, StAbortCfg
  } state_e;

  state_e     r_state;
  logic [7:0] r_len, r_cnt, r_tmr;
  logic [7:0] r_data_in, r_len_in, r_m_data;
  logic       r_wr_en, r_rd_en, r_len_wr_en, r_m_valid, r_done, r_err;

  logic w_len_ok, w_s_ready, w_accept, w_hi_last, w_lo_last, w_timeout;

  assign w_len_ok  = (i_cfg_len != 8'd0) && (32'(i_cfg_len) <= DEPTH);
  // Abort masks s_ready so the source never sees a byte accepted that is then dropped.
  assign w_s_ready = (r_state == StLdWait) && (r_cnt != r_len) && !i_fifo_full && !i_abort;
  assign w_accept  = w_s_ready && i_s_valid;
  assign w_hi_last = (r_tmr == 8'(STROBE_HI - 1));
  assign w_lo_last = (r_tmr == 8'(STROBE_LO - 1));

`ifdef FIFO_PKT_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CYC + 1);
  logic [StallW-1:0] r_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state != StLdWait) || w_accept) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + StallW'(1);
    end
  end

  assign w_timeout = (r_state == StLdWait) && (r_stall == StallW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_len       <= 8'd0;
      r_cnt       <= 8'd0;
      r_tmr       <= 8'd0;
      r_data_in   <= 8'd0;
      r_len_in    <= 8'd0;
      r_m_data    <= 8'd0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_len_wr_en <= 1'b0;
      r_m_valid   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_abort) begin
      r_state     <= StAbort;
      r_cnt       <= 8'd0;
      r_tmr       <= 8'd0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_len_wr_en <= 1'b0;
      r_m_valid   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_len       <= i_cfg_len;
              r_len_in    <= i_cfg_len;
              r_len_wr_en <= 1'b1;
              r_err       <= 1'b0;
              r_cnt       <= 8'd0;
              r_state     <= StCfg;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StCfg: begin
          r_len_wr_en <= 1'b0;
          r_tmr       <= 8'd0;
          r_state     <= StLdWait;
        end
        StLdWait: begin
          r_tmr <= 8'd0;
          if (r_cnt == r_len) begin
            r_cnt   <= 8'd0;
            r_rd_en <= 1'b1;
            r_state <= StRdHi;
          end else if (i_fifo_full) begin
            // Early full: drain only what was actually written.
            r_err <= 1'b1;
            r_len <= r_cnt;
            r_cnt <= 8'd0;
            if (r_cnt == 8'd0) begin
              r_state <= StIdle;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= StRdHi;
            end
          end else if (w_accept) begin
            r_data_in <= i_s_data;
            r_wr_en   <= 1'b1;
            r_state   <= StWrHi;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= StAbort;
          end
        end
        StWrHi: begin
          if (w_hi_last) begin
            r_wr_en <= 1'b0;
            r_tmr   <= 8'd0;
            r_state <= StWrLo;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        StWrLo: begin
          if (w_lo_last) begin
            r_cnt   <= r_cnt + 8'd1;
            r_tmr   <= 8'd0;
            r_state <= StLdWait;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        StRdHi: begin
          if (w_hi_last) begin
            r_m_data  <= i_fifo_data_out;
            r_m_valid <= 1'b1;
            r_tmr     <= 8'd0;
            r_state   <= StRdHold;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        StRdHold: begin
          if (i_m_ready) begin
            r_m_valid <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tmr     <= 8'd0;
            r_state   <= StRdLo;
          end
        end
        StRdLo: begin
          if (w_lo_last) begin
            r_tmr <= 8'd0;
            r_cnt <= r_cnt + 8'd1;
            if ((r_cnt + 8'd1) == r_len) begin
              r_done  <= 1'b1;
              r_state <= StFin;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= StRdHi;
            end
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        StFin: r_state <= StIdle;
        StAbort: begin
          r_len_wr_en <= 1'b1;
          r_len_in    <= 8'd0;
          r_state     <= StAbortCfg;
        end
        StAbortCfg: begin
          r_len_wr_en <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_s_ready           = w_s_ready;
  assign o_m_data            = r_m_data;
  assign o_m_valid           = r_m_valid;
  assign o_fifo_wr_en        = r_wr_en;
  assign o_fifo_rd_en        = r_rd_en;
  assign o_fifo_length_wr_en = r_len_wr_en;
  assign o_fifo_length_rd_en = 1'b0;
  assign o_fifo_data_in      = r_data_in;
  assign o_fifo_length_in    = r_len_in;
  assign o_busy              = (r_state != StIdle);
  assign o_done              = r_done;
  assign o_err               = r_err;

endmodule

// File: tb/tb_fifo_pkt_ctrl.sv
// Bench for fifo_pkt_ctrl: behavioural edge-detecting 128x8 fifo plus a downstream scoreboard.
// The FIFO_PKT_TIMEOUT_EN build additionally runs the load-stall timeout case.
`timescale 1ns/1ps
module tb_fifo_pkt_ctrl;
  localparam int unsigned StrobeHi = 2;
  localparam int unsigned StrobeLo = 2;
  localparam int          Depth    = 128;

  logic       clk = 1'b0;
  logic       rst, start, abort, s_valid, m_ready;
  logic [7:0] cfg_len, s_data;
  logic       s_ready, m_valid, wr_en, rd_en, len_wr_en, len_rd_en, busy, done, err;
  logic [7:0] m_data, data_in, len_in, fifo_dout;
  logic       fifo_full;

  always #5 clk = ~clk;

  fifo_pkt_ctrl #(
    .DEPTH      (Depth),
    .STROBE_HI  (StrobeHi),
    .STROBE_LO  (StrobeLo),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_start            (start),
    .i_abort            (abort),
    .i_cfg_len          (cfg_len),
    .i_s_data           (s_data),
    .i_s_valid          (s_valid),
    .o_s_ready          (s_ready),
    .o_m_data           (m_data),
    .o_m_valid          (m_valid),
    .i_m_ready          (m_ready),
    .o_fifo_wr_en       (wr_en),
    .o_fifo_rd_en       (rd_en),
    .o_fifo_length_wr_en(len_wr_en),
    .o_fifo_length_rd_en(len_rd_en),
    .o_fifo_data_in     (data_in),
    .o_fifo_length_in   (len_in),
    .i_fifo_data_out    (fifo_dout),
    .i_fifo_full        (fifo_full),
    .o_busy             (busy),
    .o_done             (done),
    .o_err              (err)
  );

  // Fifo model: push on wr_en rise, pop on rd_en fall, cleared by a length write.
  logic [7:0] mem [0:Depth-1];
  int   wp, rp, fcnt, max_cnt;
  logic wr_q, rd_q, f_push, f_pop;

  assign f_push    = wr_en && !wr_q && (fcnt < Depth);
  assign f_pop     = !rd_en && rd_q && (fcnt > 0);
  assign fifo_full = (fcnt >= Depth);
  assign fifo_dout = rd_en ? mem[rp] : 8'h1F;

  always @(posedge clk) begin
    wr_q <= wr_en;
    rd_q <= rd_en;
    if (rst || len_wr_en) begin
      wp <= 0; rp <= 0; fcnt <= 0; max_cnt <= 0;
    end else begin
      if (f_push) begin
        mem[wp] <= data_in;
        wp <= (wp + 1) % Depth;
      end
      if (f_pop) rp <= (rp + 1) % Depth;
      fcnt <= fcnt + (f_push ? 1 : 0) - (f_pop ? 1 : 0);
      if (fcnt > max_cnt) max_cnt <= fcnt;
    end
  end

  int         checks = 0, errors = 0;
  logic [7:0] exp_q [$];
  int         done_cnt = 0, len_wr_cnt = 0, last_len = -1, popped = 0;
  int         wr_run = 0, rd_run = 0, stall_left = 0, stall_at = 0;
  bit         ign_strobe = 0, hold_seen = 0;
  logic [7:0] hold_val;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: scoreboard pops, held-byte stability, strobe widths and overlaps.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (done) done_cnt++;
      if (len_wr_en) begin
        len_wr_cnt++;
        last_len = int'(len_in);
      end
      if (wr_en && rd_en) fail("wr_rd_overlap");
      if (len_wr_en && (wr_en || rd_en)) fail("len_strobe_overlap");
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail("unexpected_byte");
        else chk("m_data", int'(m_data), int'(exp_q.pop_front()));
        popped++;
        hold_seen = 0;
      end else if (m_valid) begin
        if (hold_seen) chk("hold_m_data", int'(m_data), int'(hold_val));
        else begin
          hold_seen = 1;
          hold_val  = m_data;
        end
        chk("hold_rd_en", int'(rd_en), 1);
      end
      if (wr_en) wr_run++;
      else begin
        if (wr_run != 0 && !ign_strobe) chk("wr_strobe_len", wr_run, StrobeHi);
        wr_run = 0;
      end
      if (rd_en) begin
        if (!m_valid) rd_run++;
      end else begin
        if (rd_run != 0 && !ign_strobe) chk("rd_strobe_len", rd_run, StrobeHi);
        rd_run = 0;
      end
    end
  end

  // Downstream ready: optionally held low for stall_left cycles on byte number stall_at.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && m_valid && popped == stall_at) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [7:0] len);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    int n;
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail("s_ready_timeout");
    tick();
    s_valid = 1'b0;
    if (keep) exp_q.push_back(b);
  endtask

  task automatic wait_done(input string nm);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done_cnt - d0, 1);
    repeat (2) @(negedge clk);
    chk({nm, "_once"}, done_cnt - d0, 1);
    chk({nm, "_idle"}, int'(busy), 0);
    chk({nm, "_drained"}, exp_q.size(), 0);
    tick();
  endtask

  initial begin
    int d0, l0, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_len = 8'd0; s_data = 8'd0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_strobes", int'({wr_en, rd_en, len_wr_en, len_rd_en}), 0);
    chk("rst_handshake", int'({s_ready, m_valid}), 0);
    chk("rst_data", int'({m_data, data_in, len_in}), 0);
    tick();
    rst = 1'b0;

    // Basic 4-byte packet.
    start_pkt(8'd4);
    send(8'hA1, 1); send(8'hB2, 1); send(8'hC3, 1); send(8'hD4, 1);
    chk("t1_len_write", last_len, 4);
    wait_done("t1_done");
    chk("t1_err", int'(err), 0);

    // Oversize length is rejected without a length write.
    l0 = len_wr_cnt;
    start_pkt(8'd200);
    @(negedge clk);
    chk("len200_err", int'(err), 1);
    chk("len200_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("len200_no_write", len_wr_cnt - l0, 0);
    tick();

    // Downstream stall on the second byte.
    stall_at   = popped + 1;
    stall_left = 10;
    start_pkt(8'd3);
    chk("t3_err_cleared", int'(err), 0);
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    wait_done("t3_done");
    chk("t3_stall_used", stall_left, 0);

    // Zero length is rejected.
    l0 = len_wr_cnt;
    start_pkt(8'd0);
    @(negedge clk);
    chk("len0_err", int'(err), 1);
    chk("len0_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    chk("len0_no_write", len_wr_cnt - l0, 0);
    tick();

    // Full-depth packet.
    start_pkt(8'd128);
    chk("t5_err_cleared", int'(err), 0);
    for (int i = 0; i < 128; i++) send(8'(i * 3 + 7), 1);
    wait_done("t5_done");
    chk("t5_fifo_filled", max_cnt, Depth);
    chk("t5_err", int'(err), 0);
    chk("t5_len_write", last_len, 128);

    // Abort during the third byte's write strobe.
    d0 = done_cnt;
    l0 = len_wr_cnt;
    start_pkt(8'd4);
    send(8'h5A, 0); send(8'h6B, 0); send(8'h7C, 0);
    ign_strobe = 1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_strobes", int'({wr_en, rd_en, len_wr_en}), 0);
    chk("abort_handshake", int'({s_ready, m_valid}), 0);
    @(negedge clk);
    chk("abort_len_wr", int'(len_wr_en), 1);
    chk("abort_len_val", int'(len_in), 0);
    @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_len_writes", len_wr_cnt - l0, 2);
    ign_strobe = 0;
    tick();
    start_pkt(8'd2);
    send(8'hEE, 1); send(8'hFF, 1);
    wait_done("post_abort_done");

`ifdef FIFO_PKT_TIMEOUT_EN
    // One byte, then silence: 4 write-strobe cycles plus 16 stall cycles before err shows.
    l0 = len_wr_cnt;
    start_pkt(8'd3);
    send(8'h42, 0);
    ign_strobe = 1;
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycle", n, 21);
    repeat (3) @(negedge clk);
    chk("timeout_len_val", last_len, 0);
    chk("timeout_len_writes", len_wr_cnt - l0, 2);
    chk("timeout_idle", int'(busy), 0);
    chk("timeout_err", int'(err), 1);
    ign_strobe = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    fail("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
